// File: rtl/mac_array_core.sv
// N x N signed MAC array: shadow/active weights, 4-cycle row pipeline, K-tile partial sums.
// Build option: MACARRAY_SAT_EN makes the column sum and partial-sum add saturate instead of wrap.
module mac_array_core #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int MROWS = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        W_LOAD,
  input  logic [$clog2(N)-1:0]        W_ROW,
  input  logic [N*DW-1:0]             W_DATA,
  input  logic                        I_VALID,
  input  logic [N*DW-1:0]             I_DATA,
  input  logic                        I_LAST,
  input  logic                        ACC,
  output logic                        O_VALID,
  output logic [((MROWS > 1) ? $clog2(MROWS) : 1)-1:0] O_ROW,
  output logic [N*AW-1:0]             O_DATA,
  output logic                        TILE_DONE,
  output logic                        BUSY
);

  localparam int RW = (MROWS > 1) ? $clog2(MROWS) : 1;
  localparam int PW = 2 * DW;
  localparam int XW = ((AW > PW + 5) ? AW : PW + 5) + 1;
  localparam logic signed [XW-1:0] SMAX = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  function automatic logic [AW-1:0] fit(input logic signed [XW-1:0] x);
`ifdef MACARRAY_SAT_EN
    if (x > SMAX)      fit = SMAX[AW-1:0];
    else if (x < SMIN) fit = SMIN[AW-1:0];
    else               fit = x[AW-1:0];
`else
    fit = x[AW-1:0];
`endif
  endfunction

  logic [DW-1:0]          r_wsh  [N][N];
  logic [DW-1:0]          r_wact [N][N];
  logic                   r_pend;
  logic [RW-1:0]          r_rc;
  logic [AW-1:0]          r_p    [MROWS][N];

  logic                   r_v0, r_acc0, r_done0;
  logic [N*DW-1:0]        r_i0;
  logic [RW-1:0]          r_row0;
  logic                   r_v1, r_acc1, r_done1;
  logic signed [PW-1:0]   r_p1   [N][N];
  logic [RW-1:0]          r_row1;
  logic                   r_v2, r_acc2, r_done2;
  logic [AW-1:0]          r_s2   [N];
  logic [RW-1:0]          r_row2;
  logic                   r_v3, r_done3;
  logic [RW-1:0]          r_row3;
  logic [N*AW-1:0]        r_o3;

  logic                   w_start, w_commit, w_done;
  logic signed [XW-1:0]   w_col  [N];
  logic signed [XW-1:0]   w_add  [N];

  assign w_start  = I_VALID && (r_rc == '0);
  assign w_commit = w_start && r_pend;
  assign w_done   = I_LAST || (r_rc == RW'(MROWS - 1));

  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_col[c] = '0;
      for (int k = 0; k < N; k++)
        w_col[c] = w_col[c] + XW'(r_p1[k][c]);
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_add[c] = XW'($signed(r_s2[c]));
      if (r_acc2)
        w_add[c] = w_add[c] + XW'($signed(r_p[r_row2][c]));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < N; k++)
        for (int c = 0; c < N; c++) begin
          r_wsh[k][c]  <= '0;
          r_wact[k][c] <= '0;
          r_p1[k][c]   <= '0;
        end
      for (int r = 0; r < MROWS; r++)
        for (int c = 0; c < N; c++)
          r_p[r][c] <= '0;
      for (int c = 0; c < N; c++)
        r_s2[c] <= '0;
      r_pend  <= 1'b0;
      r_rc    <= '0;
      r_v0    <= 1'b0;
      r_acc0  <= 1'b0;
      r_done0 <= 1'b0;
      r_i0    <= '0;
      r_row0  <= '0;
      r_v1    <= 1'b0;
      r_acc1  <= 1'b0;
      r_done1 <= 1'b0;
      r_row1  <= '0;
      r_v2    <= 1'b0;
      r_acc2  <= 1'b0;
      r_done2 <= 1'b0;
      r_row2  <= '0;
      r_v3    <= 1'b0;
      r_done3 <= 1'b0;
      r_row3  <= '0;
      r_o3    <= '0;
    end else begin
      if (W_LOAD)
        for (int c = 0; c < N; c++)
          r_wsh[W_ROW][c] <= W_DATA[c*DW +: DW];
      // The commit takes the pre-write shadow; a same-cycle write re-arms pending.
      if (W_LOAD)        r_pend <= 1'b1;
      else if (w_commit) r_pend <= 1'b0;
      if (w_commit)      r_wact <= r_wsh;

      if (I_VALID)
        r_rc <= w_done ? '0 : r_rc + 1'b1;

      r_v0    <= I_VALID;
      r_i0    <= I_DATA;
      r_row0  <= r_rc;
      r_acc0  <= ACC;
      r_done0 <= w_done;

      r_v1    <= r_v0;
      r_row1  <= r_row0;
      r_acc1  <= r_acc0;
      r_done1 <= r_done0;
      for (int k = 0; k < N; k++)
        for (int c = 0; c < N; c++)
          r_p1[k][c] <= $signed(r_i0[k*DW +: DW]) * $signed(r_wact[k][c]);

      r_v2    <= r_v1;
      r_row2  <= r_row1;
      r_acc2  <= r_acc1;
      r_done2 <= r_done1;
      for (int c = 0; c < N; c++)
        r_s2[c] <= fit(w_col[c]);

      r_v3    <= r_v2;
      r_done3 <= r_v2 & r_done2;
      if (r_v2) begin
        r_row3 <= r_row2;
        for (int c = 0; c < N; c++) begin
          r_o3[c*AW +: AW] <= fit(w_add[c]);
          r_p[r_row2][c]   <= fit(w_add[c]);
        end
      end
    end
  end

  assign O_VALID   = r_v3;
  assign O_ROW     = r_row3;
  assign O_DATA    = r_o3;
  assign TILE_DONE = r_done3;
  assign BUSY      = r_v0 | r_v1 | r_v2 | r_v3 | (r_rc != '0);

endmodule
